// File: rtl/vga_pattern_pkg.sv
// Shared mode encodings, default 640x480@60 timing and counter-sizing helpers
// for the VGA pattern generator and its timing core.
package vga_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Counters are at least 8 bits so the gradient can always take [7:0].
    function automatic int cnt_width(input int total);
        int w;
        w = $clog2(total + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters with combinational sync/active decode and line/frame end strobes.
// Outputs reflect the current counter state; callers register them as needed.
module vga_timing_gen
    import vga_pattern_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    localparam int  HW = cnt_width(calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    localparam int  VW = cnt_width(calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          clk,
    input  logic          srst,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          line_end,
    output logic          frame_end
);

    localparam int H_TOTAL  = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [HW-1:0] hcnt_reg;
    logic [VW-1:0] vcnt_reg;

    assign line_end  = (hcnt_reg == HW'(H_TOTAL - 1));
    assign frame_end = line_end && (vcnt_reg == VW'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (srst) begin
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else if (line_end) begin
            hcnt_reg <= '0;
            vcnt_reg <= (vcnt_reg == VW'(V_TOTAL - 1)) ? '0 : vcnt_reg + 1'b1;
        end else begin
            hcnt_reg <= hcnt_reg + 1'b1;
        end
    end

    assign hcnt   = hcnt_reg;
    assign vcnt   = vcnt_reg;
    assign active = (hcnt_reg < HW'(H_ACTIVE)) && (vcnt_reg < VW'(V_ACTIVE));

    // vcnt only moves on the hcnt wrap, so vsync changes on the line boundary.
    assign hsync = ((hcnt_reg >= HW'(HS_START)) && (hcnt_reg < HW'(HS_END))) ? HSYNC_POL : ~HSYNC_POL;
    assign vsync = ((vcnt_reg >= VW'(VS_START)) && (vcnt_reg < VW'(VS_END))) ? VSYNC_POL : ~VSYNC_POL;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing plus four selectable test patterns; every output is registered one
// cycle behind the raster counters. Pattern mode is only latched at frame end.
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int   COLOR_W    = 2,
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic HSYNC_POL  = 1'b0,
    parameter logic VSYNC_POL  = 1'b0,
    parameter int   CHECK_LOG2 = 5
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [1:0]         mode_i,
    input  logic               enable_i,
    output logic [COLOR_W-1:0] vga_red_o,
    output logic [COLOR_W-1:0] vga_green_o,
    output logic [COLOR_W-1:0] vga_blue_o,
    output logic               horiz_sync,
    output logic               vert_sync,
    output logic               blank_o,
    output logic               frame_start_o,
    output logic [7:0]         frame_cnt_o
);

    localparam int HW    = cnt_width(calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW    = cnt_width(calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int SUB_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [COLOR_W-1:0] ONE = {COLOR_W{1'b1}};

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          active, hsync, vsync, line_end, frame_end;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL)
    ) u_timing (
        .clk      (wb_clk_i),
        .srst     (wb_rst_i),
        .hcnt     (hcnt),
        .vcnt     (vcnt),
        .active   (active),
        .hsync    (hsync),
        .vsync    (vsync),
        .line_end (line_end),
        .frame_end(frame_end)
    );

    mode_t              mode_reg;
    logic [7:0]         frame_cnt_reg;
    logic [SUB_W-1:0]   bar_sub_reg;
    logic [2:0]         bar_idx_reg;
    logic [COLOR_W-1:0] red_reg, green_reg, blue_reg;
    logic [COLOR_W-1:0] red_next, green_next, blue_next;
    logic               hsync_reg, vsync_reg, blank_reg, frame_start_reg;
    logic [7:0]         grad_sum;
    logic [2:0]         bar_bits;

    // Bar index tracks hcnt without a divider: it is valid for the current hcnt.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || line_end) begin
            bar_sub_reg <= '0;
            bar_idx_reg <= '0;
        end else if (bar_sub_reg == SUB_W'(BAR_W - 1)) begin
            bar_sub_reg <= '0;
            bar_idx_reg <= bar_idx_reg + 3'd1;
        end else begin
            bar_sub_reg <= bar_sub_reg + 1'b1;
        end
    end

    always_comb begin
        red_next   = '0;
        green_next = '0;
        blue_next  = '0;
        grad_sum   = hcnt[7:0] + frame_cnt_reg;
        bar_bits   = ~bar_idx_reg;
        if (active && enable_i) begin
            case (mode_reg)
                MODE_SOLID: begin
                    red_next   = ONE;
                    green_next = ONE;
                    blue_next  = ONE;
                end
                MODE_BARS: begin
                    red_next   = {COLOR_W{bar_bits[2]}};
                    green_next = {COLOR_W{bar_bits[1]}};
                    blue_next  = {COLOR_W{bar_bits[0]}};
                end
                MODE_CHECK: begin
                    if (!(hcnt[CHECK_LOG2] ^ vcnt[CHECK_LOG2])) begin
                        red_next   = ONE;
                        green_next = ONE;
                        blue_next  = ONE;
                    end
                end
                MODE_GRAD: begin
                    red_next   = grad_sum[7 -: COLOR_W];
                    green_next = vcnt[7 -: COLOR_W];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            red_reg         <= '0;
            green_reg       <= '0;
            blue_reg        <= '0;
            blank_reg       <= 1'b1;
            hsync_reg       <= ~HSYNC_POL;
            vsync_reg       <= ~VSYNC_POL;
            frame_start_reg <= 1'b0;
            frame_cnt_reg   <= '0;
            mode_reg        <= MODE_SOLID;
        end else begin
            red_reg         <= red_next;
            green_reg       <= green_next;
            blue_reg        <= blue_next;
            blank_reg       <= ~active;
            hsync_reg       <= hsync;
            vsync_reg       <= vsync;
            frame_start_reg <= (hcnt == '0) && (vcnt == '0);
            if (frame_end) begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
                mode_reg      <= mode_t'(mode_i);
            end
        end
    end

    assign vga_red_o     = red_reg;
    assign vga_green_o   = green_reg;
    assign vga_blue_o    = blue_reg;
    assign horiz_sync    = hsync_reg;
    assign vert_sync     = vsync_reg;
    assign blank_o       = blank_reg;
    assign frame_start_o = frame_start_reg;
    assign frame_cnt_o   = frame_cnt_reg;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: four instances (default line timing, checkerboard, tiny frame,
// 800x600 active-high) sharing one clock, each with its own reset/mode/enable.
module tb_vga_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_main, rst_s, en_on, en_s;
    logic [1:0] mode_b, mode_c, mode_s, mode_l;

    logic [1:0] red_b, green_b, blue_b, red_c, green_c, blue_c;
    logic [1:0] red_s, green_s, blue_s, red_l, green_l, blue_l;
    logic       hs_b, vs_b, blank_b, fs_b, hs_c, vs_c, blank_c, fs_c;
    logic       hs_s, vs_s, blank_s, fs_s, hs_l, vs_l, blank_l, fs_l;
    logic [7:0] fc_b, fc_c, fc_s, fc_l;
    logic [5:0] rgb_b, rgb_c, rgb_s;

    assign rgb_b = {red_b, green_b, blue_b};
    assign rgb_c = {red_c, green_c, blue_c};
    assign rgb_s = {red_s, green_s, blue_s};

    // B: default horizontal timing, 5-line frame (4000 clocks)
    vga_pattern_gen #(.V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_b (
        .wb_clk_i(clk), .wb_rst_i(rst_main), .mode_i(mode_b), .enable_i(en_on),
        .vga_red_o(red_b), .vga_green_o(green_b), .vga_blue_o(blue_b),
        .horiz_sync(hs_b), .vert_sync(vs_b), .blank_o(blank_b),
        .frame_start_o(fs_b), .frame_cnt_o(fc_b));

    // C: 80x48 frame (3840 clocks), 32-pixel checker squares
    vga_pattern_gen #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
                      .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4), .CHECK_LOG2(5)) u_c (
        .wb_clk_i(clk), .wb_rst_i(rst_main), .mode_i(mode_c), .enable_i(en_on),
        .vga_red_o(red_c), .vga_green_o(green_c), .vga_blue_o(blue_c),
        .horiz_sync(hs_c), .vert_sync(vs_c), .blank_o(blank_c),
        .frame_start_o(fs_c), .frame_cnt_o(fc_c));

    // S: 12x7 frame (84 clocks) for frame-level behaviour
    vga_pattern_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_s (
        .wb_clk_i(clk), .wb_rst_i(rst_s), .mode_i(mode_s), .enable_i(en_s),
        .vga_red_o(red_s), .vga_green_o(green_s), .vga_blue_o(blue_s),
        .horiz_sync(hs_s), .vert_sync(vs_s), .blank_o(blank_s),
        .frame_start_o(fs_s), .frame_cnt_o(fc_s));

    // L: 800x600 timing with active-high syncs
    vga_pattern_gen #(.H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
                      .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
                      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) u_l (
        .wb_clk_i(clk), .wb_rst_i(rst_main), .mode_i(mode_l), .enable_i(en_on),
        .vga_red_o(red_l), .vga_green_o(green_l), .vga_blue_o(blue_l),
        .horiz_sync(hs_l), .vert_sync(vs_l), .blank_o(blank_l),
        .frame_start_o(fs_l), .frame_cnt_o(fc_l));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        if (obs === exp) $display("ok   %s = %0h", tag, obs);
    endtask

    // After step(), outputs show the pixel whose index (since release) is cyc-1.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int target);
        while (cyc - 1 < target) step();
    endtask

    initial begin
        int low_b, fall_b0, fall_b1, high_l, rise_l0, rise_l1, s_org;
        logic prev_hs_b, prev_hs_l;

        rst_main = 1'b1; rst_s = 1'b1;
        en_on = 1'b1; en_s = 1'b1;
        mode_b = 2'd1; mode_c = 2'd2; mode_s = 2'd1; mode_l = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("b_reset", 32'({rgb_b, blank_b, hs_b, vs_b, fs_b, fc_b}), 32'({6'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0}));
        check("s_reset", 32'({rgb_s, blank_s, hs_s, vs_s, fs_s, fc_s}), 32'({6'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0}));
        check("l_reset_syncs", 32'({hs_l, vs_l, blank_l}), 32'({1'b0, 1'b0, 1'b1}));
        rst_main = 1'b0; rst_s = 1'b0;

        low_b = 0; fall_b0 = -1; fall_b1 = -1;
        high_l = 0; rise_l0 = -1; rise_l1 = -1;
        prev_hs_b = 1'b1; prev_hs_l = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (i < 800 && hs_b == 1'b0) low_b++;
            if (hs_b == 1'b0 && prev_hs_b == 1'b1) begin
                if (fall_b0 < 0) fall_b0 = i;
                else if (fall_b1 < 0) fall_b1 = i;
            end
            if (i < 1056 && hs_l == 1'b1) high_l++;
            if (hs_l == 1'b1 && prev_hs_l == 1'b0) begin
                if (rise_l0 < 0) rise_l0 = i;
                else if (rise_l1 < 0) rise_l1 = i;
            end
            prev_hs_b = hs_b;
            prev_hs_l = hs_l;
            if (i == 0)   check("b_px0", 32'({rgb_b, blank_b, fs_b, fc_b}), 32'({6'h3F, 1'b0, 1'b1, 8'd0}));
            if (i == 1)   check("b_fs_px1", 32'(fs_b), 32'(1'b0));
            if (i == 639) check("b_px639", 32'({rgb_b, blank_b}), 32'({6'h3F, 1'b0}));
            if (i == 640) check("b_px640", 32'({rgb_b, blank_b}), 32'({6'h00, 1'b1}));
        end
        check("b_hsync_low_width", low_b, 96);
        check("b_hsync_first_low", fall_b0, 656);
        check("b_line_period", fall_b1 - fall_b0, 800);
        check("l_hsync_high_width", high_l, 128);
        check("l_hsync_first_high", rise_l0, 840);
        check("l_line_period", rise_l1 - rise_l0, 1056);
        check("l_vsync_idle", 32'(vs_l), 32'(1'b0));

        goto(3840); check("c_f1_00", 32'({rgb_c, fs_c, fc_c}), 32'({6'h3F, 1'b1, 8'd1}));
        goto(3872); check("c_32_0", 32'({rgb_c, blank_c}), 32'({6'h00, 1'b0}));
        goto(4000); check("b_bar0", 32'({rgb_b, fs_b, fc_b}), 32'({6'h3F, 1'b1, 8'd1}));
        goto(4079); check("b_px79", 32'(rgb_b), 32'(6'h3F));
        goto(4080); check("b_px80", 32'(rgb_b), 32'(6'h3C));
        goto(4560); check("b_px560", 32'({rgb_b, blank_b}), 32'({6'h00, 1'b0}));
        goto(4640); check("b_px640_f1", 32'({rgb_b, blank_b}), 32'({6'h00, 1'b1}));
        goto(4799); check("b_px799_f1", 32'({rgb_b, blank_b}), 32'({6'h00, 1'b1}));
        goto(6400); check("c_0_32", 32'({rgb_c, blank_c}), 32'({6'h00, 1'b0}));
        goto(6432); check("c_32_32", 32'(rgb_c), 32'(6'h3F));

        // S is in frame 78, line 3, pixel 4 (bar 4) just before its mid-frame reset
        goto(6592); check("s_pre_reset", 32'({rgb_s, fc_s}), 32'({6'h0F, 8'd78}));
        rst_s = 1'b1;
        step();
        check("s_mid_reset", 32'({rgb_s, blank_s, hs_s, vs_s, fs_s, fc_s}), 32'({6'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0}));
        rst_s = 1'b0;
        mode_s = 2'd0;
        s_org = cyc;

        goto(s_org + 0);  check("s_px0", 32'({rgb_s, blank_s, fs_s, fc_s}), 32'({6'h3F, 1'b0, 1'b1, 8'd0}));
        goto(s_org + 1);  check("s_px1_solid", 32'(rgb_s), 32'(6'h3F));
        goto(s_org + 24); mode_s = 2'd1;
        goto(s_org + 37); check("s_after_switch", 32'(rgb_s), 32'(6'h3F));
        goto(s_org + 59); check("s_vs_line4", 32'(vs_s), 32'(1'b1));
        goto(s_org + 60); check("s_vs_line5", 32'({vs_s, blank_s, rgb_s}), 32'({1'b0, 1'b1, 6'h00}));
        goto(s_org + 71); check("s_vs_line5_end", 32'(vs_s), 32'(1'b0));
        goto(s_org + 72); check("s_vs_line6", 32'(vs_s), 32'(1'b1));
        goto(s_org + 84); check("s_f1_start", 32'({rgb_s, fs_s, fc_s}), 32'({6'h3F, 1'b1, 8'd1}));
        goto(s_org + 85); check("s_bar1", 32'(rgb_s), 32'(6'h3C));
        goto(s_org + 91); check("s_bar7", 32'({rgb_s, blank_s}), 32'({6'h00, 1'b0}));
        goto(s_org + 92); check("s_hblank", 32'({rgb_s, blank_s}), 32'({6'h00, 1'b1}));
        goto(s_org + 98); check("s_bar2", 32'(rgb_s), 32'(6'h33));
        en_s = 1'b0;
        goto(s_org + 99);  check("s_disable", 32'({rgb_s, blank_s, hs_s, vs_s}), 32'({6'h00, 1'b0, 1'b1, 1'b1}));
        goto(s_org + 105); check("s_disable_hs", 32'({rgb_s, hs_s}), 32'({6'h00, 1'b0}));
        goto(s_org + 107); en_s = 1'b1;
        goto(s_org + 108); check("s_reenable", 32'(rgb_s), 32'(6'h3F));
        mode_s = 2'd3;

        goto(s_org + 21000); check("s_grad_h0_f250", 32'({rgb_s, fc_s}), 32'({6'h30, 8'd250}));
        goto(s_org + 21005); check("s_grad_h5", 32'(rgb_s), 32'(6'h30));
        goto(s_org + 21006); check("s_grad_h6_wrap", 32'({rgb_s, blank_s}), 32'({6'h00, 1'b0}));
        goto(s_org + 21420); check("s_fc255", 32'({fs_s, fc_s}), 32'({1'b1, 8'd255}));
        goto(s_org + 21504); check("s_fc_wrap", 32'({fs_s, fc_s}), 32'({1'b1, 8'd0}));
        goto(s_org + 21505); check("s_fs_clear", 32'(fs_s), 32'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
